mc_controller: RTL
==================

# mc_controller

Multicycle MIPS control unit: a Moore main-decoder FSM plus combinational ALU decoder that sequences the multicycle datapath. It consumes `op`/`funct` from the instruction register and the ALU `zero` flag. It drives every datapath control point: mux selects, register-file write enable, memory write, IR enable, and the PC enable (the `en` input of the PC `flopren`). It sits directly upstream of the datapath muxes, register file and enabled flops.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; forces state to FETCH.
- `op` input 6: instruction opcode, instr[31:26].
- `funct` input 6: R-type function field, instr[5:0].
- `zero` input 1: ALU zero flag of the current cycle's ALU result.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memwrite` output 1: data memory write enable.
- `irwrite` output 1: instruction register enable.
- `regdst` output 1: write-register select; 0 = rt, 1 = rd.
- `memtoreg` output 1: write-data select; 0 = ALUOut, 1 = Data.
- `regwrite` output 1: register file `we3`.
- `alusrca` output 1: SrcA select; 0 = PC, 1 = A.
- `alusrcb` output 2: SrcB select; 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` output 2: PC next select; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol` output 3: ALU operation code.
- `pcen` output 1: PC register enable.
- `state` output 4: current FSM state (debug).

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12.
- Transitions:
  - FETCH→DECODE.
  - DECODE selects by opcode:
    - lw (100011) or sw (101011) → MEMADR.
    - R-type (000000) → RTYPEEX.
    - beq (000100) → BEQEX.
    - addi (001000) → ADDIEX.
    - j (000010) → JEX.
    - bne (000101) → BNEEX (macro only).
    - Any other opcode → FETCH (executes as NOP).
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB; RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX → FETCH.
  - Undefined state codes → FETCH.
- Moore outputs per state. Every output not listed is 0.
  - FETCH: alusrcb=01, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - BNEEX: same as BEQEX, but asserts branchne=1 instead of branch.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- `aluop` is an internal 2-bit signal.
  - aluop=00 → alucontrol=010 (add).
  - aluop=01 → alucontrol=110 (sub).
  - aluop=10 → alucontrol decoded from funct:
    - 100000 → 010 (add).
    - 100010 → 110 (sub).
    - 100100 → 000 (and).
    - 100101 → 001 (or).
    - 101010 → 111 (slt).
    - Any other funct → 010.
- `pcen` = pcwrite | (branch & zero) | (branchne & ~zero). This is the only combinational dependency on an input (`zero`) besides `alucontrol` on `funct`.

## Timing
- Reset, asynchronous: state=FETCH immediately.
  - While `reset`=1, irwrite, pcen, regwrite and memwrite are forced to 0.
  - All other outputs take FETCH values: alusrcb=01, alucontrol=010, the rest 0.
- First FETCH occurs on the first rising edge after reset deasserts.
- Reset asserted mid-instruction aborts it. No write enable fires after the reset edge.
- Cycles per instruction, FETCH inclusive:
  - lw 5.
  - sw 4.
  - R-type 4.
  - addi 4.
  - beq/bne 3.
  - j 3.
  - Undefined opcode 2.
- `op`/`funct` are sampled only in DECODE, MEMADR and RTYPEEX. The IR holds them stable because irwrite=0 outside FETCH.
- No handshakes; memory is single-cycle combinational read.

## Configuration
- Macro `MC_BNE_EN`.
- Defined: opcode 000101 transitions DECODE→BNEEX, and the branch is taken when zero=0.
- Undefined: BNEEX state and branchne logic are absent; opcode 000101 is undefined and returns DECODE→FETCH with pcen=0 in DECODE.

## Test plan
- Reset: hold reset=1 for 2 cycles with op=100011 → state=0, pcen=0, irwrite=0, regwrite=0, memwrite=0, alusrcb=01. After release, state sequence is 0,1,2,3,4,0.
- lw then sw: op=100011 then 101011.
  - lw: MEMWB shows regwrite=1, memtoreg=1, regdst=0.
  - sw: MEMWR shows memwrite=1, iord=1. Exactly one memwrite cycle per sw.
- R-type sweep: op=000000 with funct 100000/100010/100100/100101/101010 → in RTYPEEX, alucontrol=010/110/000/001/111. RTYPEWB shows regdst=1, regwrite=1.
- beq: op=000100.
  - zero=1 in BEQEX → pcen=1, pcsrc=01, alucontrol=110.
  - zero=0 → pcen=0.
  - Both cases take 3 cycles, then FETCH.
- j and illegal opcode:
  - op=000010 → JEX with pcsrc=10, pcen=1.
  - op=111111 → DECODE→FETCH with no regwrite/memwrite asserted.
- Mid-instruction reset and macro:
  - Assert reset during MEMRD → state=0 asynchronously, no MEMWB regwrite.
  - With `MC_BNE_EN`, op=000101 and zero=0 → pcen=1 in state 12.
  - Without the macro, op=000101 → 2-cycle NOP.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit.
// A Moore main-decoder FSM sequences the multicycle datapath. A combinational
// ALU decoder turns the internal aluop plus funct into alucontrol.
//
// Optional feature macro: MC_BNE_EN adds the BNEEX state, which handles the
// bne opcode (000101).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; forces state to FETCH
//   op, funct  opcode and R-type function field from the IR
//   zero       ALU zero flag of the current cycle
//   iord       memory address select (0 PC, 1 ALUOut)
//   memwrite   data memory write enable
//   irwrite    instruction register enable
//   regdst     write-register select (0 rt, 1 rd)
//   memtoreg   write-data select (0 ALUOut, 1 Data)
//   regwrite   register file write enable
//   alusrca    SrcA select (0 PC, 1 A)
//   alusrcb    SrcB select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   pcsrc      PC next select (00 ALUResult, 01 ALUOut, 10 jump target)
//   alucontrol ALU operation code
//   pcen       PC register enable
//   state      current FSM state (debug)
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
    JEX     = 4'd11,
    BNEEX   = 4'd12
`else
    JEX     = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t     r_state;
  state_t     w_next;

  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [1:0] w_aluop;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_branchtaken;
`ifdef MC_BNE_EN
  logic       w_branchne;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       w_next = BNEEX;
`endif
          default:      w_next = FETCH;
        endcase
      end
      // MEMADR is only reachable from lw or sw.
      MEMADR:  w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   w_next = MEMWB;
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
`ifdef MC_BNE_EN
    w_branchne = 1'b0;
`endif
    case (r_state)
      FETCH:   begin w_alusrcb = 2'b01; w_irwrite = 1'b1; w_pcwrite = 1'b1; end
      DECODE:  w_alusrcb = 2'b11;
      MEMADR:  begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
      MEMRD:   w_iord = 1'b1;
      MEMWB:   begin w_memtoreg = 1'b1; w_regwrite = 1'b1; end
      MEMWR:   begin w_iord = 1'b1; w_memwrite = 1'b1; end
      RTYPEEX: begin w_alusrca = 1'b1; w_aluop = 2'b10; end
      RTYPEWB: begin w_regdst = 1'b1; w_regwrite = 1'b1; end
      BEQEX:   begin w_alusrca = 1'b1; w_aluop = 2'b01; w_pcsrc = 2'b01; w_branch = 1'b1; end
`ifdef MC_BNE_EN
      BNEEX:   begin w_alusrca = 1'b1; w_aluop = 2'b01; w_pcsrc = 2'b01; w_branchne = 1'b1; end
`endif
      ADDIEX:  begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
      ADDIWB:  w_regwrite = 1'b1;
      JEX:     begin w_pcsrc = 2'b10; w_pcwrite = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (w_aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
  end

`ifdef MC_BNE_EN
  assign w_branchtaken = (w_branch & zero) | (w_branchne & ~zero);
`else
  assign w_branchtaken = w_branch & zero;
`endif

  // The state register already sits at FETCH while reset is held. Masking the
  // write enables with reset keeps FETCH from writing the IR or the PC until
  // reset is released.
  assign pcen     = (w_pcwrite | w_branchtaken) & ~reset;
  assign irwrite  = w_irwrite  & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign memwrite = w_memwrite & ~reset;

  assign iord     = w_iord;
  assign regdst   = w_regdst;
  assign memtoreg = w_memtoreg;
  assign alusrca  = w_alusrca;
  assign alusrcb  = w_alusrcb;
  assign pcsrc    = w_pcsrc;
  assign state    = r_state;

endmodule
